// File: rtl/axi_burst_driver.sv
// Single-outstanding AXI4 master moving one cache line per request as a LINE_BEATS-beat burst; AW and W issue concurrently.
// AXI_BURST_DRIVER_CWF_EN selects critical-word-first refill (WRAP read from the beat-aligned request address).
module axi_burst_driver #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int LINE_BEATS     = 4,
   localparam int LINE_BITS     = LINE_BEATS*AXI_DATA_WIDTH,
   localparam int OFS           = $clog2(LINE_BEATS*AXI_DATA_WIDTH/8)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_is_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [LINE_BITS-1:0]        req_wdata,
   input  logic [LINE_BITS/8-1:0]      req_wstrb,
   output logic                        resp_valid,
   output logic [LINE_BITS-1:0]        resp_data,
   output logic                        resp_err,
   output logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
   output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]                  M_AXI_AWLEN,
   output logic [2:0]                  M_AXI_AWSIZE,
   output logic [1:0]                  M_AXI_AWBURST,
   output logic                        M_AXI_AWVALID,
   input  logic                        M_AXI_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                        M_AXI_WLAST,
   output logic                        M_AXI_WVALID,
   input  logic                        M_AXI_WREADY,
   input  logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
   input  logic [1:0]                  M_AXI_BRESP,
   input  logic                        M_AXI_BVALID,
   output logic                        M_AXI_BREADY,
   output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
   output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]                  M_AXI_ARLEN,
   output logic [2:0]                  M_AXI_ARSIZE,
   output logic [1:0]                  M_AXI_ARBURST,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   input  logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
   input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP,
   input  logic                        M_AXI_RLAST,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY
);
   localparam int STRB_W = AXI_DATA_WIDTH/8;
   localparam int SIZE   = $clog2(STRB_W);
   localparam int CW     = $clog2(LINE_BEATS);

   typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD_AR, RD_DATA, DONE} state_t;

   state_t                    state_q;
   logic [LINE_BITS-1:0]      wbuf_q, rbuf_q;
   logic [LINE_BITS/8-1:0]    sbuf_q;
   logic [CW-1:0]             wcnt_q, rcnt_q;
   logic [CW:0]               rbeats_q;
   logic                      is_write_q, aw_done_q, w_done_q, err_q;
   logic [CW-1:0]             wcnt_d, rcnt_init_d;
   logic [AXI_ADDR_WIDTH-1:0] line_addr_d, rd_addr_d;
   logic                      aw_hs, w_hs, r_err_d, unused_addr_bits;

   assign line_addr_d = {req_addr[AXI_ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
   assign wcnt_d      = wcnt_q + CW'(1);
   assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
   // Early RLAST and beats beyond the line both flag an error; surplus beats are dropped.
   assign r_err_d = (M_AXI_RRESP != 2'b00) || (M_AXI_RID != '0)
                 || (rbeats_q == (CW+1)'(LINE_BEATS))
                 || (M_AXI_RLAST && (rbeats_q != (CW+1)'(LINE_BEATS-1)));
   assign unused_addr_bits = ^req_addr[OFS-1:0];

`ifdef AXI_BURST_DRIVER_CWF_EN
   assign rd_addr_d     = {req_addr[AXI_ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
   assign rcnt_init_d   = req_addr[OFS-1:SIZE];
   assign M_AXI_ARBURST = 2'b10;
`else
   assign rd_addr_d     = line_addr_d;
   assign rcnt_init_d   = '0;
   assign M_AXI_ARBURST = 2'b01;
`endif

   assign M_AXI_AWID    = '0;
   assign M_AXI_ARID    = '0;
   assign M_AXI_AWLEN   = 8'(LINE_BEATS-1);
   assign M_AXI_ARLEN   = 8'(LINE_BEATS-1);
   assign M_AXI_AWSIZE  = 3'(SIZE);
   assign M_AXI_ARSIZE  = 3'(SIZE);
   assign M_AXI_AWBURST = 2'b01;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wbuf_q        <= '0;
         rbuf_q        <= '0;
         sbuf_q        <= '0;
         wcnt_q        <= '0;
         rcnt_q        <= '0;
         rbeats_q      <= '0;
         is_write_q    <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         err_q         <= 1'b0;
         req_ready     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_data     <= '0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_WLAST   <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready  <= 1'b0;
                  is_write_q <= req_is_write;
                  wbuf_q     <= req_wdata;
                  sbuf_q     <= req_wstrb;
                  rcnt_q     <= rcnt_init_d;
                  if (req_is_write) begin
                     M_AXI_AWADDR  <= line_addr_d;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     M_AXI_WDATA   <= req_wdata[AXI_DATA_WIDTH-1:0];
                     M_AXI_WSTRB   <= req_wstrb[STRB_W-1:0];
                     M_AXI_WLAST   <= 1'b0;
                     state_q       <= WR;
                  end else begin
                     M_AXI_ARADDR  <= rd_addr_d;
                     M_AXI_ARVALID <= 1'b1;
                     state_q       <= RD_AR;
                  end
               end
            end
            WR: begin
               if (aw_hs) begin
                  M_AXI_AWVALID <= 1'b0;
                  aw_done_q     <= 1'b1;
               end
               if (w_hs) begin
                  if (M_AXI_WLAST) begin
                     M_AXI_WVALID <= 1'b0;
                     M_AXI_WLAST  <= 1'b0;
                     w_done_q     <= 1'b1;
                  end else begin
                     wcnt_q      <= wcnt_d;
                     M_AXI_WDATA <= wbuf_q[int'(wcnt_d)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                     M_AXI_WSTRB <= sbuf_q[int'(wcnt_d)*STRB_W +: STRB_W];
                     M_AXI_WLAST <= (wcnt_d == CW'(LINE_BEATS-1));
                  end
               end
               // AW and the last W may complete in either order or together.
               if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && M_AXI_WLAST))) begin
                  M_AXI_BREADY <= 1'b1;
                  state_q      <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (M_AXI_BVALID) begin
                  err_q        <= err_q || (M_AXI_BRESP != 2'b00) || (M_AXI_BID != '0);
                  M_AXI_BREADY <= 1'b0;
                  state_q      <= DONE;
               end
            end
            RD_AR: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state_q       <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (M_AXI_RVALID) begin
                  if (rbeats_q != (CW+1)'(LINE_BEATS)) begin
                     rbuf_q[int'(rcnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= M_AXI_RDATA;
                     rcnt_q   <= rcnt_q + CW'(1);
                     rbeats_q <= rbeats_q + (CW+1)'(1);
                  end
                  err_q <= err_q || r_err_d;
                  if (M_AXI_RLAST) begin
                     M_AXI_RREADY <= 1'b0;
                     state_q      <= DONE;
                  end
               end
            end
            DONE: begin
               resp_valid <= 1'b1;
               resp_err   <= err_q;
               resp_data  <= is_write_q ? '0 : rbuf_q;
               req_ready  <= 1'b1;
               err_q      <= 1'b0;
               wcnt_q     <= '0;
               rbeats_q   <= '0;
               aw_done_q  <= 1'b0;
               w_done_q   <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_driver.sv
// Bench for axi_burst_driver: scoreboarded AXI slave model, expected W beats and responses queued at request time.
module tb_axi_burst_driver;
   localparam int AW = 32, DW = 64, IW = 4, LB = 4, LBITS = LB*DW;
`ifdef AXI_BURST_DRIVER_CWF_EN
   localparam logic [1:0] EXP_ARBURST = 2'b10;
`else
   localparam logic [1:0] EXP_ARBURST = 2'b01;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, req_valid, req_ready, req_is_write, resp_valid, resp_err;
   logic [AW-1:0] req_addr;
   logic [LBITS-1:0] req_wdata, resp_data;
   logic [LBITS/8-1:0] req_wstrb;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready;
   logic rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;

   axi_burst_driver #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .LINE_BEATS(LB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready));

   typedef struct packed { logic [LBITS-1:0] data; logic err; } resp_t;
   typedef struct packed { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } wbeat_t;
   resp_t  exp_resp_q[$];
   wbeat_t exp_w_q[$];
   int n_tests = 0, n_fail = 0;
   int r_hs_cnt, last_w_rel, aw_rel;

   task automatic idle_inputs();
      req_valid = 0; req_is_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0; arready = 0;
      rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
   endtask

   task automatic push_write(input logic [LBITS-1:0] line, input logic [LBITS/8-1:0] strb);
      for (int k = 0; k < LB; k++)
         exp_w_q.push_back({line[k*DW +: DW], strb[k*(DW/8) +: DW/8], (k == LB-1)});
      exp_resp_q.push_back({{LBITS{1'b0}}, 1'b0});
   endtask

   // Zero-wait AXI slave except for the AWREADY delay and optional RVALID toggling; abort_w>0 asserts rst
   // when that many W beats have been accepted.
   task automatic drive_line(input bit is_wr, input logic [AW-1:0] addr, input logic [LBITS-1:0] line,
                             input logic [LBITS/8-1:0] strb, input int aw_delay, input bit r_toggle,
                             input int err_beat, input logic [AW-1:0] exp_addr, input int exp_lat,
                             input int abort_w);
      int cyc, acc, aw_wait, w_n, r_idx;
      bit acc_done, aw_got, b_pend, b_seen, r_act, phase, done, aborted;
      resp_t er; wbeat_t ew;
      cyc = 0; acc = 0; aw_wait = 0; w_n = 0; r_idx = 0; r_hs_cnt = 0; last_w_rel = -1; aw_rel = -1;
      acc_done = 0; aw_got = 0; b_pend = 0; b_seen = 0; r_act = 0; phase = 0; done = 0; aborted = 0;
      req_valid = 1; req_is_write = is_wr; req_addr = addr; req_wdata = is_wr ? line : '0; req_wstrb = strb;
      while (!done && cyc < 300) begin
         if (acc_done) req_valid = 0;
         if (abort_w > 0 && w_n == abort_w) begin
            rst = 1; aborted = 1; idle_inputs();
            break;
         end
         awready = (aw_wait >= aw_delay); wready = 1; bvalid = b_pend; bresp = 2'b00; bid = '0;
         arready = 1; rid = '0;
         rvalid = r_act && (!r_toggle || phase);
         rdata = (r_idx < LB) ? line[r_idx*DW +: DW] : '0;
         rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
         rlast = r_act && (r_idx == LB-1);
         if (resp_valid) begin
            n_tests++;
            if (exp_resp_q.size() == 0) begin
               n_fail++; $display("FAIL resp_unexpected got data=%h err=%b", resp_data, resp_err);
            end else begin
               er = exp_resp_q.pop_front();
               if (resp_data !== er.data) begin
                  n_fail++; $display("FAIL resp_data got=%h exp=%h", resp_data, er.data);
               end
               n_tests++;
               if (resp_err !== er.err) begin
                  n_fail++; $display("FAIL resp_err got=%b exp=%b", resp_err, er.err);
               end
            end
            if (exp_lat > 0) begin
               n_tests++;
               if (cyc - acc != exp_lat) begin
                  n_fail++; $display("FAIL latency got=%0d exp=%0d", cyc - acc, exp_lat);
               end
            end
            done = 1;
         end
         if (bready) begin
            n_tests++;
            if (!(aw_got && w_n == LB)) begin
               n_fail++; $display("FAIL bready_early got aw=%b w=%0d exp aw=1 w=%0d", aw_got, w_n, LB);
            end
         end
         if (req_valid && req_ready && !acc_done) begin acc = cyc; acc_done = 1; end
         if (awvalid && awready) begin
            n_tests++;
            if ({awaddr, awlen, awsize, awburst} !== {exp_addr, 8'd3, 3'd3, 2'b01}) begin
               n_fail++; $display("FAIL aw_fields got=%h/%0d/%0d/%0d exp=%h/3/3/1", awaddr, awlen, awsize, awburst, exp_addr);
            end
            aw_got = 1; aw_rel = cyc - acc;
         end else if (awvalid) aw_wait++;
         if (wvalid && wready) begin
            n_tests++;
            if (exp_w_q.size() == 0) begin
               n_fail++; $display("FAIL w_unexpected got=%h", wdata);
            end else begin
               ew = exp_w_q.pop_front();
               if ({wdata, wstrb, wlast} !== ew) begin
                  n_fail++; $display("FAIL w_beat got=%h/%h/%b exp=%h/%h/%b", wdata, wstrb, wlast, ew.data, ew.strb, ew.last);
               end
            end
            w_n++;
            if (w_n == LB) last_w_rel = cyc - acc;
         end
         if (bvalid && bready) begin b_pend = 0; b_seen = 1; end
         else if (aw_got && w_n == LB && !b_seen) b_pend = 1;
         if (r_act) phase = !phase;
         if (arvalid && arready) begin
            n_tests++;
            if ({araddr, arlen, arsize, arburst} !== {exp_addr, 8'd3, 3'd3, EXP_ARBURST}) begin
               n_fail++; $display("FAIL ar_fields got=%h/%0d/%0d/%0d exp=%h/3/3/%0d", araddr, arlen, arsize, arburst, exp_addr, EXP_ARBURST);
            end
            r_act = 1; phase = 1;
         end
         if (rvalid && rready) begin
            r_idx++; r_hs_cnt++;
            if (r_idx == LB) r_act = 0;
         end
         @(negedge clk); cyc++;
      end
      if (!aborted) begin
         idle_inputs();
         n_tests++;
         if (!done) begin
            n_fail++; $display("FAIL timeout got=%0d cycles exp=resp_valid", cyc);
         end else if (resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL resp_pulse got=%b exp=0", resp_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl got=%b exp=00000000", {req_ready, awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err});
      end
      n_tests++;
      if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
      n_tests++;
      if ({awaddr, araddr, wdata, wstrb, wlast} !== '0) begin
         n_fail++; $display("FAIL reset_payload got=%h/%h/%h/%h/%b exp=0", awaddr, araddr, wdata, wstrb, wlast);
      end
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
   endtask

   task automatic test_write_basic();
      logic [LBITS-1:0] line = {64'h3333_4444_5555_6666, 64'h2222_3333_4444_5555, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF};
      logic [LBITS/8-1:0] strb = 32'hFF0F_F001;
      push_write(line, strb);
      drive_line(1, 32'h1000_0024, line, strb, 0, 0, -1, 32'h1000_0020, 7, 0);
   endtask

   task automatic test_aw_stall();
      logic [LBITS-1:0] line = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      push_write(line, '1);
      drive_line(1, 32'h0000_2008, line, '1, 5, 0, -1, 32'h0000_2000, 0, 0);
      n_tests++;
      if (last_w_rel != LB) begin n_fail++; $display("FAIL w_no_stall got=%0d exp=%0d", last_w_rel, LB); end
      n_tests++;
      if (aw_rel != 6) begin n_fail++; $display("FAIL aw_after_stall got=%0d exp=6", aw_rel); end
      n_tests++;
      if (exp_resp_q.size() != 0) begin n_fail++; $display("FAIL stall_resp_count got=%0d exp=0 left", exp_resp_q.size()); end
   endtask

   task automatic test_read_toggle();
      logic [LBITS-1:0] line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      exp_resp_q.push_back({line, 1'b0});
      drive_line(0, 32'h0000_0040, line, '0, 0, 1, -1, 32'h0000_0040, 0, 0);
   endtask

   task automatic test_read_slverr();
      logic [LBITS-1:0] line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
      exp_resp_q.push_back({line, 1'b1});
      drive_line(0, 32'h0000_0080, line, '0, 0, 0, 1, 32'h0000_0080, 7, 0);
      n_tests++;
      if (r_hs_cnt != LB) begin n_fail++; $display("FAIL slverr_beats got=%0d exp=%0d", r_hs_cnt, LB); end
   endtask

   task automatic test_cwf();
      logic [LBITS-1:0] arrival = {64'hB1, 64'hB0, 64'hB3, 64'hB2};
`ifdef AXI_BURST_DRIVER_CWF_EN
      exp_resp_q.push_back({{64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b0});
      drive_line(0, 32'h0000_0050, arrival, '0, 0, 0, -1, 32'h0000_0050, 7, 0);
`else
      exp_resp_q.push_back({arrival, 1'b0});
      drive_line(0, 32'h0000_0050, arrival, '0, 0, 0, -1, 32'h0000_0040, 7, 0);
`endif
   endtask

   task automatic test_back_to_back();
      logic [LBITS-1:0] wl = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      logic [LBITS-1:0] rl = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
      push_write(wl, '1);
      drive_line(1, 32'h0000_3000, wl, '1, 0, 0, -1, 32'h0000_3000, 7, 0);
      exp_resp_q.push_back({rl, 1'b0});
      drive_line(0, 32'h0000_3020, rl, '0, 0, 0, -1, 32'h0000_3020, 7, 0);
   endtask

   task automatic test_reset_mid();
      logic [LBITS-1:0] line = {64'h93, 64'h92, 64'h91, 64'h90};
      logic [LBITS-1:0] rl = {64'h87, 64'h86, 64'h85, 64'h84};
      push_write(line, '1);
      drive_line(1, 32'h0000_4000, line, '1, 0, 0, -1, 32'h0000_4000, 0, 2);
      @(negedge clk);
      n_tests++;
      if ({awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready} !== 7'b0) begin
         n_fail++; $display("FAIL mid_reset_valids got=%b exp=0000000", {awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready});
      end
      exp_w_q.delete(); exp_resp_q.delete();
      rst = 0;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_idle got=%b exp=1", req_ready); end
      exp_resp_q.push_back({rl, 1'b0});
      drive_line(0, 32'h0000_5000, rl, '0, 0, 0, -1, 32'h0000_5000, 7, 0);
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_aw_stall();
      test_read_toggle();
      test_read_slverr();
      test_cwf();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
